// File: rtl/address_sequencer.sv
// Address-register load controller and fetch/data arbiter for the single memory port.
// Optional ACCESS watchdog enabled by defining ADDR_SEQ_TIMEOUT_EN.
module address_sequencer #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic [4:0] data_count,
    input  logic       mem_ready,
    output logic [1:0] addr_sel,
    output logic       addr_update,
    output logic       mem_req,
    output logic       is_data,
    output logic       busy,
    output logic       done,
    output logic [4:0] words_left,
    output logic       timeout_err
);

    typedef enum logic [2:0] {IDLE, LOAD, ACCESS, STEP, FINISH} state_e;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_PC  = 2'b01;
    localparam logic [1:0] SEL_INC = 2'b10;

    if (MAX_BURST < 1 || MAX_BURST > 31) begin : g_bad_max_burst
        $error("address_sequencer: MAX_BURST must be within 1..31");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("address_sequencer: TIMEOUT must be at least 1");
    end

    state_e     state_q, state_d;
    logic [4:0] words_q, words_d;
    logic       is_data_q, is_data_d;
    logic       timeout_q, timeout_d;

`ifdef ADDR_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    function automatic logic [4:0] clamp_count(input logic [4:0] count);
        if (count == 5'd0)
            return 5'd1;
        else if (32'(count) > MAX_BURST)
            return 5'(MAX_BURST);
        else
            return count;
    endfunction

    // NOTE: every variable gets its default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        is_data_d = is_data_q;
        timeout_d = 1'b0;
`ifdef ADDR_SEQ_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                is_data_d = 1'b0;
                if (data_req) begin
                    state_d   = LOAD;
                    is_data_d = 1'b1;
                    words_d   = clamp_count(data_count);
                end else if (fetch_req) begin
                    state_d = LOAD;
                    words_d = 5'd1;
                end
            end
            LOAD, STEP: begin
                state_d = ACCESS;
`ifdef ADDR_SEQ_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ACCESS: begin
                if (mem_ready) begin
                    words_d = words_q - 5'd1;
                    state_d = (words_q == 5'd1) ? FINISH : STEP;
                end
`ifdef ADDR_SEQ_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abort skips FINISH so no done pulse is produced.
                    state_d   = IDLE;
                    words_d   = 5'd0;
                    is_data_d = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            FINISH: begin
                state_d   = IDLE;
                words_d   = 5'd0;
                is_data_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            words_q   <= 5'd0;
            is_data_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            words_q   <= words_d;
            is_data_q <= is_data_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef ADDR_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt_q <= '0;
        else
            wait_cnt_q <= wait_cnt_d;
    end
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
    logic unused_timeout;
    assign unused_timeout = timeout_q;
`endif

    // Outputs decode from state and registers only; no input reaches an output directly.
    always_comb begin
        addr_sel = SEL_PC;
        if (state_q == LOAD)
            addr_sel = is_data_q ? SEL_ALU : SEL_PC;
        else if (state_q == STEP)
            addr_sel = SEL_INC;
    end

    assign addr_update = (state_q == LOAD) || (state_q == STEP);
    assign mem_req     = (state_q == ACCESS);
    assign is_data     = is_data_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FINISH);
    assign words_left  = words_q;

endmodule

// File: tb/tb_address_sequencer.sv
// Self-checking bench: per-cycle expected outputs derived from a transaction-level model.
module tb_address_sequencer;

    localparam int MAX_BURST = 16;
`ifdef ADDR_SEQ_TIMEOUT_EN
    localparam int TIMEOUT = 5;
`else
    localparam int TIMEOUT = 255;
`endif

    logic       clk, reset, fetch_req, data_req, mem_ready;
    logic [4:0] data_count;
    logic [1:0] addr_sel;
    logic       addr_update, mem_req, is_data, busy, done, timeout_err;
    logic [4:0] words_left;

    address_sequencer #(.MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .data_req(data_req),
        .data_count(data_count), .mem_ready(mem_ready), .addr_sel(addr_sel),
        .addr_update(addr_update), .mem_req(mem_req), .is_data(is_data),
        .busy(busy), .done(done), .words_left(words_left), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {sel[1:0], update, mem_req, is_data, busy, done, words[4:0], timeout_err}
    logic [12:0] act;
    assign act = {addr_sel, addr_update, mem_req, is_data, busy, done, words_left, timeout_err};

    localparam logic [12:0] RESET_VEC = {2'b01, 11'b0};

    typedef struct {
        logic [12:0] outs;
        logic        chk_sel;
        logic        rdy;
        logic        fin;
    } cyc_t;

    cyc_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    function automatic logic [12:0] vec(logic [1:0] sel, logic upd, logic mreq, logic isd,
                                        logic bsy, logic dn, logic [4:0] w, logic terr);
        return {sel, upd, mreq, isd, bsy, dn, w, terr};
    endfunction

    task automatic push(logic [12:0] v, logic chk_sel, logic rdy, logic fin);
        cyc_t c;
        c.outs = v; c.chk_sel = chk_sel; c.rdy = rdy; c.fin = fin;
        exp_q.push_back(c);
    endtask

    // One grant from request to the following IDLE cycle; entered just after a negedge in IDLE.
    task automatic run_txn(input logic d, input logic [4:0] cnt, input int min_wait,
                           input int max_wait, input logic keep_fetch, input string name);
        int n;
        logic [1:0] load_sel;
        n = !d ? 1 : (cnt == 0) ? 1 : (int'(cnt) > MAX_BURST) ? MAX_BURST : int'(cnt);
        load_sel = d ? 2'b00 : 2'b01;
        exp_q.delete();
        push(vec(load_sel, 1, 0, d, 1, 0, 5'(n), 0), 1'b1, 1'($urandom), 1'b0);
        for (int w = n; w >= 1; w--) begin
            int waits = int'($urandom_range(max_wait, min_wait));
            repeat (waits) push(vec(2'b00, 0, 1, d, 1, 0, 5'(w), 0), 1'b0, 1'b0, 1'b0);
            push(vec(2'b00, 0, 1, d, 1, 0, 5'(w), 0), 1'b0, 1'b1, 1'b0);
            if (w > 1)
                push(vec(2'b10, 1, 0, d, 1, 0, 5'(w - 1), 0), 1'b1, 1'($urandom), 1'b0);
            else
                push(vec(2'b00, 0, 0, d, 1, 1, 5'd0, 0), 1'b0, 1'($urandom), 1'b1);
        end
        push(RESET_VEC, 1'b1, 1'($urandom), 1'b0);

        if (d) data_req = 1'b1; else fetch_req = 1'b1;
        if (keep_fetch) fetch_req = 1'b1;
        data_count = cnt;
        mem_ready  = 1'($urandom);
        foreach (exp_q[i]) begin
            logic [12:0] m;
            @(negedge clk);
            m = exp_q[i].chk_sel ? 13'h1FFF : 13'h07FF;
            total++;
            if ((act & m) !== (exp_q[i].outs & m))
                $display("FAIL %s cycle %0d: got %b expected %b (mask %b)",
                         name, i, act, exp_q[i].outs, m);
            else
                passed++;
            mem_ready  = exp_q[i].rdy;
            data_count = 5'($urandom);
            if (exp_q[i].fin) begin
                data_req  = 1'b0;
                fetch_req = keep_fetch;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; mem_ready = 1'b0; data_count = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (act !== RESET_VEC) $display("FAIL reset_held: got %b expected %b", act, RESET_VEC);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (act !== RESET_VEC) $display("FAIL reset_idle: got %b expected %b", act, RESET_VEC);
        else passed++;
    endtask

    task automatic test_fetch();
        run_txn(1'b0, 5'd0, 0, 0, 1'b0, "fetch_zero_wait");
    endtask

    task automatic test_burst();
        run_txn(1'b1, 5'd4, 0, 0, 1'b0, "burst4");
    endtask

    task automatic test_arbitration();
        fetch_req = 1'b1;
        run_txn(1'b1, 5'd3, 0, 1, 1'b1, "arb_data");
        run_txn(1'b0, 5'd0, 0, 1, 1'b0, "arb_fetch");
    endtask

    task automatic test_clamp_and_waits();
        run_txn(1'b1, 5'd0,  0, 2, 1'b0, "count0");
        run_txn(1'b1, 5'd20, 0, 0, 1'b0, "count20");
        run_txn(1'b1, 5'd31, 0, 1, 1'b0, "count31");
        run_txn(1'b1, 5'd16, 0, 0, 1'b0, "count16");
        run_txn(1'b1, 5'd3,  3, 3, 1'b0, "wait3");
        run_txn(1'b0, 5'd0,  3, 3, 1'b0, "fetch_wait3");
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            logic d, kf;
            d  = 1'($urandom);
            kf = d & 1'($urandom);
            if (kf) fetch_req = 1'b1;
            run_txn(d, 5'($urandom), 0, 3, kf, "random");
            if (kf) run_txn(1'b0, 5'($urandom), 0, 3, 1'b0, "random_pending_fetch");
        end
    endtask

    task automatic test_reset_mid_burst();
        data_req = 1'b1; data_count = 5'd4; mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({mem_req, words_left} !== {1'b1, 5'd3})
            $display("FAIL mid_burst_access2: got mem_req=%b words=%0d expected 1/3", mem_req, words_left);
        else passed++;
        reset = 1'b1; data_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (act !== RESET_VEC)
                $display("FAIL reset_mid_burst cycle %0d: got %b expected %b", i, act, RESET_VEC);
            else passed++;
            @(negedge clk);
        end
    endtask

`ifdef ADDR_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [12:0] e;
        data_req = 1'b1; data_count = 5'd2; mem_ready = 1'b0;
        for (int i = 0; i < 1 + TIMEOUT + 2; i++) begin
            @(negedge clk);
            if (i == 0)            e = vec(2'b00, 1, 0, 1, 1, 0, 5'd2, 0);
            else if (i <= TIMEOUT) e = vec(2'b01, 0, 1, 1, 1, 0, 5'd2, 0);
            else if (i == TIMEOUT + 1) e = vec(2'b01, 0, 0, 0, 0, 0, 5'd0, 1);
            else                   e = RESET_VEC;
            total++;
            if ((act & 13'h07FF) !== (e & 13'h07FF))
                $display("FAIL timeout cycle %0d: got %b expected %b", i, act, e);
            else passed++;
            if (i == TIMEOUT + 1) data_req = 1'b0;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_burst();
        test_arbitration();
        test_clamp_and_waits();
        test_random();
        test_reset_mid_burst();
`ifdef ADDR_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
